// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction fetch FSM
// one bus request in flight, words handed to IF/ID in dataF
module ifetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic [96:0] dataF,
  output logic        Iwait
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic        is_bubble;
  } fetch_data_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic [31:0] ibuf_q, ibuf_d;
  fetch_data_t dataf_q, dataf_d;

  logic        dlv;
  logic [31:0] dlv_word;
  logic [63:0] redir_pc;
  logic [63:0] pc_inc;

  assign redir_pc = redirect_pc & ~64'd3;
  assign pc_inc   = pc_q + 64'd4;

  // next-state: redirect first, then response, then stall
  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    discard_d         = discard_q;
    ibuf_d            = ibuf_q;
    dataf_d           = dataf_q;
    dataf_d.is_bubble = 1'b1;
    dlv               = 1'b0;
    dlv_word          = iresp_data;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) begin
          pc_d   = redir_pc;
          ibuf_d = '0;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          pc_d      = redir_pc;
          discard_d = 1'b0;
        end else if (iresp_data_ok) begin
          if (!stall) begin
            dlv = 1'b1;
          end else begin
            ibuf_d  = iresp_data;
            state_d = HOLD;
          end
        end else if (iresp_addr_ok) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
          if (iresp_data_ok) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            discard_d = 1'b1;
          end
        end else if (iresp_data_ok) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else if (!stall) begin
            dlv = 1'b1;
          end else begin
            ibuf_d  = iresp_data;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          ibuf_d  = '0;
          state_d = REQ;
        end else if (!stall) begin
          dlv      = 1'b1;
          dlv_word = ibuf_q;
        end
      end
    endcase
    if (dlv) begin
      dataf_d.raw_instr = dlv_word;
      dataf_d.pc        = pc_q;
      dataf_d.is_bubble = 1'b0;
      pc_d              = pc_inc;
      state_d           = REQ;
    end
  end

  // state and IF/ID register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      ibuf_q    <= '0;
      dataf_q   <= '{raw_instr: '0, pc: '0, is_bubble: 1'b1};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      ibuf_q    <= ibuf_d;
      dataf_q   <= dataf_d;
    end
  end

  assign ireq_valid = (state_q == REQ);
  assign ireq_addr  = pc_q;
  assign Iwait      = (state_q == REQ) || (state_q == WAIT);
  assign dataF      = dataf_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed cases then a random bus
// checked against a fetch-stream model
module tb_ifetch_ctrl;

  localparam logic [63:0] RST = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic [96:0] dataF;
  logic        Iwait;

  logic [31:0] d_raw;
  logic [63:0] d_pc;
  logic        d_bub;

  assign d_raw = dataF[96:65];
  assign d_pc  = dataF[64:1];
  assign d_bub = dataF[0];

  int checks;
  int failures;
  int ndeliv;

  logic [63:0] exp_pc;
  logic [63:0] last_pc;
  logic [31:0] last_raw;
  logic        prev_redir;
  logic        prev_stall;
  logic [63:0] prev_tgt;
  logic        outst;
  int          cnt;
  int          lat;
  logic [63:0] oaddr;
  logic        redir;
  logic        stl;
  logic [63:0] tgt;

  ifetch_ctrl #(.RESET_PC(RST)) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_addr_ok (iresp_addr_ok),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .dataF         (dataF),
    .Iwait         (Iwait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return (a[31:0] ^ a[63:32]) * 32'h9E37_79B1 + 32'h13;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    iresp_addr_ok  = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    stall          = 1'b0;
  endtask

  // ends on a falling edge with the fetcher in REQ at RST
  task automatic rst_release();
    @(negedge clk);
    reset = 1'b1;
    idle_in();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ndeliv   = 0;
    reset    = 1'b1;
    idle_in();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    chk("rst_bub", d_bub, 1);
    chk("rst_raw", d_raw, 0);
    chk("rst_pc", d_pc, 0);
    chk("rst_valid", ireq_valid, 0);
    chk("rst_iwait", Iwait, 0);
    chk("rst_addr", ireq_addr, RST);

    // zero-latency bus, back to back
    rst_release();
    chk("b2b_valid", ireq_valid, 1);
    chk("b2b_iwait", Iwait, 1);
    iresp_addr_ok = 1'b1;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h0000_0013;
    @(negedge clk);
    chk("b2b_pc0", d_pc, RST);
    chk("b2b_raw0", d_raw, 32'h0000_0013);
    chk("b2b_bub0", d_bub, 0);
    iresp_data = 32'h0010_0093;
    @(negedge clk);
    chk("b2b_pc1", d_pc, RST + 64'd4);
    chk("b2b_raw1", d_raw, 32'h0010_0093);
    chk("b2b_bub1", d_bub, 0);
    idle_in();
    @(negedge clk);
    chk("b2b_idle_bub", d_bub, 1);
    chk("b2b_idle_pc", d_pc, RST + 64'd4);
    chk("b2b_addr", ireq_addr, RST + 64'd8);

    // data three cycles after addr_ok
    rst_release();
    iresp_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_in();
      chk("lat_iwait", Iwait, 1);
      chk("lat_valid", ireq_valid, 0);
      chk("lat_bub", d_bub, 1);
    end
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h1234_5678;
    @(negedge clk);
    idle_in();
    chk("lat_pc", d_pc, RST);
    chk("lat_raw", d_raw, 32'h1234_5678);
    chk("lat_dbub", d_bub, 0);
    chk("lat_next", ireq_addr, RST + 64'd4);
    @(negedge clk);
    chk("lat_once", d_bub, 1);

    // data under a four-cycle stall
    rst_release();
    iresp_addr_ok = 1'b1;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hCAFE_0001;
    stall         = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iresp_addr_ok = 1'b0;
      iresp_data_ok = 1'b0;
      iresp_data    = 32'h0;
      chk("hold_bub", d_bub, 1);
      chk("hold_iwait", Iwait, 0);
      chk("hold_valid", ireq_valid, 0);
      if (i == 3) stall = 1'b0;
    end
    @(negedge clk);
    chk("hold_pc", d_pc, RST);
    chk("hold_raw", d_raw, 32'hCAFE_0001);
    chk("hold_dbub", d_bub, 0);
    chk("hold_next", ireq_addr, RST + 64'd4);

    // redirect while waiting discards the old word
    rst_release();
    iresp_addr_ok = 1'b1;
    @(negedge clk);
    iresp_addr_ok  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1000;
    @(negedge clk);
    idle_in();
    chk("disc_addr", ireq_addr, 64'h8000_1000);
    chk("disc_valid", ireq_valid, 0);
    @(negedge clk);
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hBAD0_BAD0;
    @(negedge clk);
    idle_in();
    chk("disc_bub", d_bub, 1);
    chk("disc_valid2", ireq_valid, 1);
    chk("disc_addr2", ireq_addr, 64'h8000_1000);
    iresp_addr_ok = 1'b1;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h0000_0517;
    @(negedge clk);
    idle_in();
    chk("disc_pc", d_pc, 64'h8000_1000);
    chk("disc_raw", d_raw, 32'h0000_0517);

    // redirect beats data and stall
    rst_release();
    iresp_addr_ok  = 1'b1;
    iresp_data_ok  = 1'b1;
    iresp_data     = 32'h1111_1111;
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2002;
    @(negedge clk);
    idle_in();
    chk("rprio_bub", d_bub, 1);
    chk("rprio_valid", ireq_valid, 1);
    chk("rprio_addr", ireq_addr, 64'h8000_2000);

    // pc wraps modulo 2^64
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    idle_in();
    chk("wrap_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    iresp_addr_ok = 1'b1;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h2222_2222;
    @(negedge clk);
    idle_in();
    chk("wrap_pc", d_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_next", ireq_addr, 64'h0);

    // reset during WAIT, late data_ok ignored
    rst_release();
    iresp_addr_ok = 1'b1;
    @(negedge clk);
    iresp_addr_ok = 1'b0;
    reset         = 1'b1;
    #1;
    chk("rwait_valid", ireq_valid, 0);
    chk("rwait_iwait", Iwait, 0);
    @(negedge clk);
    reset         = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h3333_3333;
    @(negedge clk);
    idle_in();
    chk("rwait_bub", d_bub, 1);
    chk("rwait_valid2", ireq_valid, 1);
    chk("rwait_addr", ireq_addr, RST);
    @(negedge clk);
    chk("rwait_bub2", d_bub, 1);

    // random bus, stalls and redirects
    rst_release();
    exp_pc     = RST;
    last_pc    = 64'h0;
    last_raw   = 32'h0;
    prev_redir = 1'b0;
    prev_stall = 1'b0;
    prev_tgt   = 64'h0;
    outst      = 1'b0;
    cnt        = 0;
    oaddr      = 64'h0;
    for (int c = 0; c < 3000; c++) begin
      if (prev_stall || prev_redir) chk("rnd_no_dlv", d_bub, 1);
      if (prev_redir) begin
        exp_pc = prev_tgt & ~64'd3;
      end else if (!d_bub) begin
        chk("rnd_pc", d_pc, exp_pc);
        chk("rnd_raw", {32'h0, d_raw}, {32'h0, mem(exp_pc)});
        exp_pc = exp_pc + 64'd4;
        ndeliv++;
      end
      if (d_bub) begin
        chk("rnd_hold_pc", d_pc, last_pc);
        chk("rnd_hold_raw", d_raw, last_raw);
      end
      last_pc  = d_pc;
      last_raw = d_raw;
      chk("rnd_addr", ireq_addr, exp_pc);
      if (ireq_valid) chk("rnd_iwait", Iwait, 1);
      chk("rnd_one_outst", outst & ireq_valid, 0);

      redir = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0)
        tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else
        tgt = 64'h8000_0000 | 64'($urandom_range(0, 65535));
      stl = ($urandom_range(0, 3) == 0);
      iresp_addr_ok = 1'b0;
      iresp_data_ok = 1'b0;
      iresp_data    = $urandom;
      if (outst) begin
        if (cnt == 0) begin
          iresp_data_ok = 1'b1;
          iresp_data    = mem(oaddr);
          outst         = 1'b0;
        end else begin
          cnt--;
        end
      end else if (ireq_valid && $urandom_range(0, 2) != 0) begin
        lat = $urandom_range(0, 3);
        if (lat == 0) begin
          iresp_addr_ok = 1'b1;
          iresp_data_ok = 1'b1;
          iresp_data    = mem(ireq_addr);
        end else if (!redir) begin
          iresp_addr_ok = 1'b1;
          outst         = 1'b1;
          cnt           = lat - 1;
          oaddr         = ireq_addr;
        end
      end
      redirect_valid = redir;
      redirect_pc    = tgt;
      stall          = stl;
      prev_redir     = redir;
      prev_tgt       = tgt;
      prev_stall     = stl;
      @(negedge clk);
    end
    idle_in();
    chk("rnd_progress", ndeliv > 200, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
